// File: rtl/uart_program_loader.sv
// uart_program_loader: receives a framed test program over UART, writes its
// instruction words into the harness BRAM, validates the trailing XOR
// checksum and reports the result with an ACK/NAK byte and a start pulse.
module uart_program_loader #(
  parameter int         WORD_BYTES     = 7,
  parameter int         ADDR_W         = 8,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1200000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_byte,
  input  logic                    tx_busy,
  output logic                    tx_start,
  output logic [7:0]              tx_byte,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [8*WORD_BYTES-1:0] mem_din,
  output logic [ADDR_W-1:0]       highest_instruction,
  output logic                    program_valid,
  output logic                    start,
  output logic                    busy
);

  localparam int WORD_W = 8 * WORD_BYTES;
  localparam int BC_W   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int TMR_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_DATA,
    S_CHECK,
    S_ACK
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   count_q, count_d;
  logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
  logic [BC_W-1:0]     byte_cnt_q, byte_cnt_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [7:0]          xor_q, xor_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                tx_start_q, tx_start_d;
  logic [7:0]          tx_byte_q, tx_byte_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0]   mem_din_q, mem_din_d;
  logic [ADDR_W-1:0]   highest_q, highest_d;
  logic                valid_q, valid_d;
  logic                start_q, start_d;
  logic                busy_q, busy_d;
  logic                frame_active;
  logic                timeout_hit;

  assign frame_active = (state_q == S_COUNT) || (state_q == S_DATA) || (state_q == S_CHECK);
  assign timeout_hit  = (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));

  // Frame parser: next state, datapath updates and registered output values.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    xor_d      = xor_q;
    timer_d    = timer_q;
    tx_start_d = 1'b0;
    tx_byte_d  = tx_byte_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    highest_d  = highest_q;
    valid_d    = valid_q;
    start_d    = 1'b0;

    if (frame_active) begin
      timer_d = rx_valid ? '0 : timer_q + TMR_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (rx_valid && (rx_byte == SYNC_BYTE)) begin
          valid_d    = 1'b0;
          xor_d      = '0;
          byte_cnt_d = '0;
          word_idx_d = '0;
          timer_d    = '0;
          state_d    = S_COUNT;
        end
      end
      S_COUNT: begin
        if (rx_valid) begin
          if (rx_byte == 8'h00) begin
            tx_byte_d = NAK_BYTE;
            state_d   = S_ACK;
          end else begin
            count_d = ADDR_W'(rx_byte);
            xor_d   = xor_q ^ rx_byte;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          xor_d  = xor_q ^ rx_byte;
          word_d = {rx_byte, word_q[WORD_W-1:8]};
          if (byte_cnt_q == BC_W'(WORD_BYTES - 1)) begin
            byte_cnt_d = '0;
            mem_we_d   = 1'b1;
            mem_addr_d = word_idx_q;
            mem_din_d  = word_d;
            if (word_idx_q != count_q) begin
              word_idx_d = word_idx_q + ADDR_W'(1);
            end
            if (word_idx_q == count_q - ADDR_W'(1)) begin
              state_d = S_CHECK;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + BC_W'(1);
          end
        end
      end
      S_CHECK: begin
        if (rx_valid) begin
          if (rx_byte == xor_q) begin
            highest_d = count_q;
            valid_d   = 1'b1;
            start_d   = 1'b1;
            tx_byte_d = ACK_BYTE;
          end else begin
            tx_byte_d = NAK_BYTE;
          end
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A stalled sender abandons the frame; words already written stay put.
    if (frame_active && !rx_valid && timeout_hit) begin
      tx_byte_d = NAK_BYTE;
      state_d   = S_ACK;
    end

    busy_d = (state_d != S_IDLE) || tx_start_d;
  end

  // State and datapath registers; reset aborts any frame without touching BRAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      xor_q      <= '0;
      timer_q    <= '0;
      tx_start_q <= 1'b0;
      tx_byte_q  <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      highest_q  <= '0;
      valid_q    <= 1'b0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      xor_q      <= xor_d;
      timer_q    <= timer_d;
      tx_start_q <= tx_start_d;
      tx_byte_q  <= tx_byte_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      highest_q  <= highest_d;
      valid_q    <= valid_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_start            = tx_start_q;
  assign tx_byte             = tx_byte_q;
  assign mem_we              = mem_we_q;
  assign mem_addr            = mem_addr_q;
  assign mem_din             = mem_din_q;
  assign highest_instruction = highest_q;
  assign program_valid       = valid_q;
  assign start               = start_q;
  assign busy                = busy_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// tb_uart_program_loader: directed scenarios for the UART program loader.
module tb_uart_program_loader;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_byte;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [55:0] mem_din;
  logic [7:0]  highest_instruction;
  logic        program_valid;
  logic        start;
  logic        busy;

  int checks = 0;
  int failures = 0;

  int          we_cnt = 0;
  int          start_cnt = 0;
  int          tx_cnt = 0;
  logic [7:0]  last_tx = 8'h00;
  logic [7:0]  we_addr_log[$];
  logic [55:0] we_data_log[$];
  logic [7:0]  frame[$];

  uart_program_loader #(
    .WORD_BYTES(7),
    .ADDR_W(8),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_valid(rx_valid),
    .rx_byte(rx_byte),
    .tx_busy(tx_busy),
    .tx_start(tx_start),
    .tx_byte(tx_byte),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_din(mem_din),
    .highest_instruction(highest_instruction),
    .program_valid(program_valid),
    .start(start),
    .busy(busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Event monitor sampling outputs just after each active edge.
  always @(posedge clk) begin
    #1;
    if (mem_we) begin
      we_cnt++;
      we_addr_log.push_back(mem_addr);
      we_data_log.push_back(mem_din);
    end
    if (start) start_cnt++;
    if (tx_start) begin
      tx_cnt++;
      last_tx = tx_byte;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_burst();
    foreach (frame[i]) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_byte  = frame[i];
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_single_payload();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    send_byte(8'h66);
    send_byte(8'h77);
  endtask

  task automatic wait_ack(output bit got);
    int base;
    base = tx_cnt;
    got  = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx_cnt != base) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; tx_busy = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_start, tx_byte, mem_we, mem_addr, mem_din, highest_instruction, program_valid, start, busy} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs actual=%h expected=0",
               {tx_start, tx_byte, mem_we, mem_addr, mem_din, highest_instruction, program_valid, start, busy});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy actual=%b expected=0", busy); end
  endtask

  task automatic test_good_single();
    int st0;
    bit got;
    st0 = start_cnt;
    send_single_payload();
    checks++;
    if (mem_we !== 1'b1) begin failures++; $display("[TB] FAIL single_we actual=%b expected=1", mem_we); end
    checks++;
    if (mem_addr !== 8'h00) begin failures++; $display("[TB] FAIL single_addr actual=%h expected=00", mem_addr); end
    checks++;
    if (mem_din !== 56'h77665544332211) begin failures++; $display("[TB] FAIL single_din actual=%h expected=77665544332211", mem_din); end
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b0) begin failures++; $display("[TB] FAIL single_we_width actual=%b expected=0", mem_we); end
    // 01^11^22^33^44^55^66^77 = 01
    send_byte(8'h01);
    checks++;
    if ({start, program_valid, highest_instruction} !== {1'b1, 1'b1, 8'h01}) begin
      failures++;
      $display("[TB] FAIL single_result actual=%b/%b/%h expected=1/1/01", start, program_valid, highest_instruction);
    end
    checks++;
    if (tx_start !== 1'b0) begin failures++; $display("[TB] FAIL single_tx_early actual=%b expected=0", tx_start); end
    wait_ack(got);
    checks++;
    if (!got || last_tx !== 8'h06) begin failures++; $display("[TB] FAIL single_ack actual=%0b/%h expected=1/06", got, last_tx); end
    checks++;
    if (start_cnt !== st0 + 1) begin failures++; $display("[TB] FAIL single_start_count actual=%0d expected=%0d", start_cnt, st0 + 1); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL single_busy_end actual=%b expected=0", busy); end
  endtask

  task automatic test_bad_checksum();
    int st0, we0, tx0;
    bit got;
    st0 = start_cnt; we0 = we_cnt;
    send_single_payload();
    tx_busy = 1'b1;
    send_byte(8'h00);
    checks++;
    if ({start, program_valid} !== 2'b00) begin failures++; $display("[TB] FAIL bad_result actual=%b%b expected=00", start, program_valid); end
    checks++;
    if (we_cnt !== we0 + 1 || we_addr_log[we0] !== 8'h00) begin
      failures++; $display("[TB] FAIL bad_write actual=%0d expected=%0d", we_cnt, we0 + 1);
    end
    tx0 = tx_cnt;
    repeat (6) @(negedge clk);
    checks++;
    if (tx_cnt !== tx0 || busy !== 1'b1) begin failures++; $display("[TB] FAIL bad_tx_busy_hold actual=%0d/%b expected=%0d/1", tx_cnt, busy, tx0); end
    tx_busy = 1'b0;
    wait_ack(got);
    checks++;
    if (!got || last_tx !== 8'h15) begin failures++; $display("[TB] FAIL bad_nak actual=%0b/%h expected=1/15", got, last_tx); end
    checks++;
    if (start_cnt !== st0 || program_valid !== 1'b0 || highest_instruction !== 8'h01) begin
      failures++; $display("[TB] FAIL bad_state actual=%0d/%b/%h expected=%0d/0/01", start_cnt, program_valid, highest_instruction, st0);
    end
  endtask

  task automatic test_back_to_back();
    int st0, we0;
    bit got;
    logic [55:0] exp_word[3];
    exp_word[0] = 56'h07060504030201;
    exp_word[1] = 56'h605040302010A5;
    exp_word[2] = 56'h813CC355AA00FF;
    st0 = start_cnt; we0 = we_cnt;
    frame = '{8'hA5, 8'h03,
              8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
              8'hA5, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60,
              8'hFF, 8'h00, 8'hAA, 8'h55, 8'hC3, 8'h3C, 8'h81,
              8'hA8};
    send_burst();
    wait_ack(got);
    checks++;
    if (!got || last_tx !== 8'h06) begin failures++; $display("[TB] FAIL b2b_ack actual=%0b/%h expected=1/06", got, last_tx); end
    checks++;
    if (highest_instruction !== 8'h03 || program_valid !== 1'b1) begin
      failures++; $display("[TB] FAIL b2b_result actual=%h/%b expected=03/1", highest_instruction, program_valid);
    end
    checks++;
    if (we_cnt !== we0 + 3 || start_cnt !== st0 + 1) begin
      failures++; $display("[TB] FAIL b2b_counts actual=%0d/%0d expected=%0d/%0d", we_cnt, start_cnt, we0 + 3, st0 + 1);
    end
    for (int i = 0; i < 3; i++) begin
      if (we0 + i < we_addr_log.size()) begin
        checks++;
        if (we_addr_log[we0 + i] !== 8'(i) || we_data_log[we0 + i] !== exp_word[i]) begin
          failures++;
          $display("[TB] FAIL b2b_word%0d actual=%h:%h expected=%h:%h", i, we_addr_log[we0 + i], we_data_log[we0 + i], 8'(i), exp_word[i]);
        end
      end
    end
  endtask

  task automatic test_junk_zero_count();
    int st0, we0;
    bit got;
    st0 = start_cnt; we0 = we_cnt;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h12);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL junk_busy actual=%b expected=0", busy); end
    send_byte(8'hA5);
    send_byte(8'h00);
    wait_ack(got);
    checks++;
    if (!got || last_tx !== 8'h15) begin failures++; $display("[TB] FAIL zero_nak actual=%0b/%h expected=1/15", got, last_tx); end
    checks++;
    if (we_cnt !== we0 || start_cnt !== st0 || program_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL zero_state actual=%0d/%0d/%b expected=%0d/%0d/0", we_cnt, start_cnt, program_valid, we0, st0);
    end
  endtask

  task automatic test_timeout();
    int st0, we0, tx0;
    bit got;
    st0 = start_cnt; we0 = we_cnt;
    send_byte(8'hA5);
    send_byte(8'h02);
    for (int i = 1; i <= 10; i++) send_byte(8'(i));
    checks++;
    if (we_cnt !== we0 + 1 || we_data_log[we0] !== 56'h07060504030201 || we_addr_log[we0] !== 8'h00) begin
      failures++; $display("[TB] FAIL timeout_write actual=%0d expected=%0d", we_cnt, we0 + 1);
    end
    tx0 = tx_cnt;
    repeat (30) @(negedge clk);
    checks++;
    if (tx_cnt !== tx0 || busy !== 1'b1) begin failures++; $display("[TB] FAIL timeout_early actual=%0d/%b expected=%0d/1", tx_cnt, busy, tx0); end
    wait_ack(got);
    checks++;
    if (!got || last_tx !== 8'h15) begin failures++; $display("[TB] FAIL timeout_nak actual=%0b/%h expected=1/15", got, last_tx); end
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || program_valid !== 1'b0 || start_cnt !== st0 || we_cnt !== we0 + 1) begin
      failures++; $display("[TB] FAIL timeout_state actual=%b/%b/%0d/%0d expected=0/0/%0d/%0d", busy, program_valid, start_cnt, we_cnt, st0, we0 + 1);
    end
  endtask

  task automatic test_reset_mid_data();
    int tx0, we0;
    bit got;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    tx0 = tx_cnt;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({tx_start, tx_byte, mem_we, mem_addr, mem_din, highest_instruction, program_valid, start, busy} !== '0) begin
      failures++;
      $display("[TB] FAIL midreset_outputs actual=%h expected=0",
               {tx_start, tx_byte, mem_we, mem_addr, mem_din, highest_instruction, program_valid, start, busy});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (tx_cnt !== tx0) begin failures++; $display("[TB] FAIL midreset_no_tx actual=%0d expected=%0d", tx_cnt, tx0); end
    we0 = we_cnt;
    send_single_payload();
    send_byte(8'h01);
    wait_ack(got);
    checks++;
    if (!got || last_tx !== 8'h06 || highest_instruction !== 8'h01 || program_valid !== 1'b1) begin
      failures++; $display("[TB] FAIL midreset_reload actual=%0b/%h/%h/%b expected=1/06/01/1", got, last_tx, highest_instruction, program_valid);
    end
    checks++;
    if (we_cnt !== we0 + 1 || we_addr_log[we0] !== 8'h00 || we_data_log[we0] !== 56'h77665544332211) begin
      failures++; $display("[TB] FAIL midreset_write actual=%0d expected=%0d", we_cnt, we0 + 1);
    end
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    test_reset();
    test_good_single();
    test_bad_checksum();
    test_back_to_back();
    test_junk_zero_count();
    test_timeout();
    test_reset_mid_data();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
